// File: rtl/cr_kme_packer_pkg.sv
// Shared types and defaults for the KME FIFO packer.
// State encoding plus default beat width and pad fill value.
package cr_kme_packer_pkg;

  localparam int KME_IN_W = 32;
  localparam logic [KME_IN_W-1:0] KME_PAD_VAL = '0;

  typedef enum logic [1:0] {
    EMPTY,
    HALF,
    FULL
  } pk_state_e;

endpackage

// File: rtl/cr_kme_sticky_cnt.sv
// Wrapping debug counter with increment enable.
// Synchronous clear takes priority over increment.
module cr_kme_sticky_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/cr_kme_fifo_packer.sv
// Packs 32-bit beat pairs into 64-bit FIFO words.
// Honors the FIFO stall and tracks sticky errors and debug counts.
module cr_kme_fifo_packer
  import cr_kme_packer_pkg::*;
#(
  parameter int              IN_W    = KME_IN_W,
  parameter logic [IN_W-1:0] PAD_VAL = IN_W'(KME_PAD_VAL),
  parameter int              CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IN_W-1:0]   in_data,
  input  logic              in_valid,
  input  logic              in_last,
  output logic              in_ready,
  output logic [2*IN_W-1:0] fifo_in,
  output logic              fifo_in_valid,
  input  logic              fifo_in_stall,
  input  logic              fifo_overflow,
  input  logic              fifo_underflow,
  output logic              err_ovf,
  output logic              err_unf,
  output logic [CNT_W-1:0]  words_sent,
  output logic [CNT_W-1:0]  pads_sent
);

  pk_state_e         state;
  logic [IN_W-1:0]   low_q;
  logic [2*IN_W-1:0] word_q;
  logic              pad_q;

  logic              accept;
  logic              done_now;
  logic              launch;
  logic              pad_now;
  logic              launch_pad;
  logic [2*IN_W-1:0] word_now;
  logic [2*IN_W-1:0] launch_word;

  always_comb begin
    in_ready = !rst && (state != FULL || !fifo_in_stall);
    accept   = in_valid && in_ready;
    done_now = accept &&
               (state == HALF || (state == EMPTY && in_last));
    // Outside HALF a completing beat is always a padded tail
    word_now = (state == HALF) ? {in_data, low_q}
                               : {PAD_VAL, in_data};
    pad_now  = (state != HALF);
    launch   = !fifo_in_stall && (state == FULL || done_now);
    launch_word = (state == FULL) ? word_q : word_now;
    launch_pad  = (state == FULL) ? pad_q : pad_now;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= EMPTY;
      low_q         <= '0;
      word_q        <= '0;
      pad_q         <= 1'b0;
      fifo_in       <= '0;
      fifo_in_valid <= 1'b0;
    end else begin
      fifo_in_valid <= launch;
      if (launch) begin
        fifo_in <= launch_word;
      end
      unique case (1'b1)
        state == EMPTY: begin
          if (accept && !in_last) begin
            low_q <= in_data;
            state <= HALF;
          end else if (accept && fifo_in_stall) begin
            word_q <= word_now;
            pad_q  <= pad_now;
            state  <= FULL;
          end
        end
        state == HALF: begin
          if (accept && fifo_in_stall) begin
            word_q <= word_now;
            pad_q  <= pad_now;
            state  <= FULL;
          end else if (accept) begin
            state <= EMPTY;
          end
        end
        state == FULL: begin
          // A beat taken while launching always starts a fresh word
          if (launch && accept && in_last) begin
            word_q <= word_now;
            pad_q  <= pad_now;
            state  <= FULL;
          end else if (launch && accept) begin
            low_q <= in_data;
            state <= HALF;
          end else if (launch) begin
            state <= EMPTY;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_ovf <= 1'b0;
      err_unf <= 1'b0;
    end else begin
      err_ovf <= err_ovf | fifo_overflow;
      err_unf <= err_unf | fifo_underflow;
    end
  end

  cr_kme_sticky_cnt #(.W(CNT_W)) u_words (
    .clk   (clk),
    .clr   (rst),
    .inc   (launch),
    .count (words_sent)
  );

  cr_kme_sticky_cnt #(.W(CNT_W)) u_pads (
    .clk   (clk),
    .clr   (rst),
    .inc   (launch && launch_pad),
    .count (pads_sent)
  );

endmodule

// File: tb/tb_cr_kme_fifo_packer.sv
// Directed bench for the KME FIFO packer.
// Includes a small depth-4 FIFO occupancy model for the streaming step.
module tb_cr_kme_fifo_packer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_last = 1'b0;
  logic        in_ready;
  logic [63:0] fifo_in;
  logic        fifo_in_valid;
  logic        fifo_in_stall;
  logic        fifo_overflow;
  logic        fifo_underflow = 1'b0;
  logic        err_ovf;
  logic        err_unf;
  logic [15:0] words_sent;
  logic [15:0] pads_sent;

  logic        stall_drv = 1'b0;
  logic        ovf_drv = 1'b0;
  logic        use_model = 1'b0;
  logic [3:0]  occ = '0;
  logic [3:0]  max_occ = '0;
  logic        pop_ph = 1'b0;
  logic        tog = 1'b0;
  logic [1:0]  tcnt = '0;
  logic        model_ovf = 1'b0;
  logic [3:0]  wr_n = '0;
  logic [63:0] wr_log [0:7];
  logic        m_push;
  logic        m_pop;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  assign m_push = fifo_in_valid;
  assign m_pop  = pop_ph && (occ != 0);
  assign fifo_in_stall = use_model ? (tog || occ >= DEPTH - 1)
                                   : stall_drv;
  assign fifo_overflow = model_ovf | ovf_drv;

  cr_kme_fifo_packer #(
    .IN_W    (32),
    .PAD_VAL (32'hDEADBEEF),
    .CNT_W   (16)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_last        (in_last),
    .in_ready       (in_ready),
    .fifo_in        (fifo_in),
    .fifo_in_valid  (fifo_in_valid),
    .fifo_in_stall  (fifo_in_stall),
    .fifo_overflow  (fifo_overflow),
    .fifo_underflow (fifo_underflow),
    .err_ovf        (err_ovf),
    .err_unf        (err_unf),
    .words_sent     (words_sent),
    .pads_sent      (pads_sent)
  );

  always @(posedge clk) begin
    if (use_model) begin
      occ       <= occ + {3'b0, m_push} - {3'b0, m_pop};
      model_ovf <= m_push && !m_pop && occ == DEPTH;
      if (m_push && wr_n < 8) begin
        wr_log[wr_n[2:0]] <= fifo_in;
        wr_n <= wr_n + 1'b1;
      end
      if (occ > max_occ) max_occ <= occ;
      pop_ph <= !pop_ph;
      tcnt   <= (tcnt == 2) ? 2'd0 : tcnt + 1'b1;
      if (tcnt == 2) tog <= !tog;
    end else begin
      model_ovf <= 1'b0;
    end
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d, input logic l);
    int n;
    n = 0;
    in_data  = d;
    in_valid = 1'b1;
    in_last  = l;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("send_timeout", 64'(n < 200), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    tick();
    tick();
    chk("rst_ready", 64'(in_ready), 64'd0);
    chk("rst_valid", 64'(fifo_in_valid), 64'd0);
    chk("rst_data", fifo_in, 64'd0);
    chk("rst_words", 64'(words_sent), 64'd0);
    chk("rst_pads", 64'(pads_sent), 64'd0);
    chk("rst_errs", 64'({err_ovf, err_unf}), 64'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_ready", 64'(in_ready), 64'd1);
    chk("post_rst_valid", 64'(fifo_in_valid), 64'd0);

    // Pair
    send(32'hA, 1'b0);
    chk("pair_nostrobe", 64'(fifo_in_valid), 64'd0);
    send(32'hB, 1'b1);
    chk("pair_valid", 64'(fifo_in_valid), 64'd1);
    chk("pair_data", fifo_in, 64'h0000000B_0000000A);
    chk("pair_words", 64'(words_sent), 64'd1);
    chk("pair_pads", 64'(pads_sent), 64'd0);
    tick();
    chk("pair_one_strobe", 64'(fifo_in_valid), 64'd0);
    chk("pair_hold", fifo_in, 64'h0000000B_0000000A);

    // Odd tail
    send(32'h1234, 1'b1);
    chk("tail_valid", 64'(fifo_in_valid), 64'd1);
    chk("tail_data", fifo_in, 64'hDEADBEEF_00001234);
    chk("tail_pads", 64'(pads_sent), 64'd1);
    chk("tail_words", 64'(words_sent), 64'd2);

    // Stall hold
    stall_drv = 1'b1;
    send(32'hC, 1'b0);
    send(32'hD, 1'b1);
    chk("stall_nostrobe0", 64'(fifo_in_valid), 64'd0);
    for (int i = 0; i < 5; i++) begin
      chk("stall_ready", 64'(in_ready), 64'd0);
      tick();
      chk("stall_nostrobe", 64'(fifo_in_valid), 64'd0);
    end
    chk("stall_data_held", fifo_in, 64'hDEADBEEF_00001234);
    chk("stall_words", 64'(words_sent), 64'd2);
    stall_drv = 1'b0;
    tick();
    chk("stall_rel_valid", 64'(fifo_in_valid), 64'd1);
    chk("stall_rel_data", fifo_in, 64'h0000000D_0000000C);
    tick();
    chk("stall_rel_once", 64'(fifo_in_valid), 64'd0);

    // Streaming through the FIFO model
    use_model = 1'b1;
    for (int i = 0; i < 16; i++) begin
      send(32'h100 + 32'(i), 1'(i % 2));
    end
    begin
      int n;
      n = 0;
      while (wr_n < 8 && n < 300) begin
        tick();
        n++;
      end
      chk("stream_timeout", 64'(n < 300), 64'd1);
    end
    tick();
    tick();
    use_model = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk("stream_word", wr_log[k],
          {32'h101 + 32'(2 * k), 32'h100 + 32'(2 * k)});
    end
    chk("stream_ovf", 64'(err_ovf), 64'd0);
    chk("stream_depth", 64'(max_occ <= DEPTH), 64'd1);
    chk("stream_words", 64'(words_sent), 64'd11);
    chk("stream_pads", 64'(pads_sent), 64'd1);

    // Reset mid-frame
    send(32'h77, 1'b0);
    rst = 1'b1;
    tick();
    chk("mid_rst_ready", 64'(in_ready), 64'd0);
    chk("mid_rst_valid", 64'(fifo_in_valid), 64'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("mid_rst_after", 64'(fifo_in_valid), 64'd0);
    chk("mid_rst_words", 64'(words_sent), 64'd0);
    send(32'h5, 1'b0);
    chk("mid_rst_nostrobe", 64'(fifo_in_valid), 64'd0);
    send(32'h6, 1'b1);
    chk("mid_rst_valid2", 64'(fifo_in_valid), 64'd1);
    chk("mid_rst_data", fifo_in, 64'h00000006_00000005);
    chk("mid_rst_words2", 64'(words_sent), 64'd1);

    // Sticky errors
    fifo_underflow = 1'b1;
    tick();
    fifo_underflow = 1'b0;
    chk("unf_set", 64'(err_unf), 64'd1);
    tick();
    tick();
    chk("unf_sticky", 64'(err_unf), 64'd1);
    chk("ovf_clear", 64'(err_ovf), 64'd0);
    ovf_drv = 1'b1;
    tick();
    ovf_drv = 1'b0;
    tick();
    chk("ovf_sticky", 64'(err_ovf), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    chk("err_rst", 64'({err_ovf, err_unf}), 64'd0);

    // Counter wrap: padded beats launch one word per cycle
    in_data  = 32'h55;
    in_last  = 1'b1;
    in_valid = 1'b1;
    repeat (65535) @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("wrap_words_ffff", 64'(words_sent), 64'hFFFF);
    chk("wrap_pads_ffff", 64'(pads_sent), 64'hFFFF);
    send(32'h1, 1'b0);
    send(32'h2, 1'b1);
    chk("wrap_words_0", 64'(words_sent), 64'd0);
    chk("wrap_pads_hold", 64'(pads_sent), 64'hFFFF);
    chk("wrap_data", fifo_in, 64'h00000002_00000001);
    send(32'h3, 1'b1);
    chk("wrap_pads_0", 64'(pads_sent), 64'd0);
    chk("wrap_words_1", 64'(words_sent), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cr_kme_fifo_packer.md
# cr_kme_fifo_packer

Write-side producer for the KME 64-bit stall/ack FIFO. It accepts a 32-bit valid/ready beat stream, packs pairs of beats into 64-bit words, and drives the FIFO write port (`fifo_in`, `fifo_in_valid`). It obeys the FIFO's `fifo_in_stall`, which asserts when one or fewer slots are free. It also registers the FIFO's overflow/underflow flags as sticky errors and counts words and padded tails for debug CSRs.

## Interface
- `IN_W`, 32, input beat width; output word is `2*IN_W`
- `PAD_VAL`, 32'h0, fill value for the upper half when a frame ends on an odd beat
- `CNT_W`, 16, width of the debug counters
- `clk` in 1: the single clock; all state updates on its rising edge
- `rst` in 1: synchronous, active-high reset
- `in_data` in IN_W: input beat
- `in_valid` in 1: beat present
- `in_last` in 1: beat is the final one of its frame
- `in_ready` out 1: beat accepted when `in_valid & in_ready`
- `fifo_in` out 2*IN_W: write data to the FIFO
- `fifo_in_valid` out 1: one-cycle write strobe per word
- `fifo_in_stall` in 1: FIFO has 1 or fewer free slots, or override
- `fifo_overflow` in 1: FIFO overflow pulse
- `fifo_underflow` in 1: FIFO underflow pulse
- `err_ovf` out 1: sticky; set by `fifo_overflow`
- `err_unf` out 1: sticky; set by `fifo_underflow`
- `words_sent` out CNT_W: words written, wraps
- `pads_sent` out CNT_W: padded words written, wraps

## Operation
- State machine:
  - EMPTY: no half held.
  - HALF: low half `[IN_W-1:0]` held.
  - FULL: 64-bit word complete, waiting to launch.
- EMPTY + beat:
  - `in_last=0` → store the low half, go to HALF.
  - `in_last=1` → word = {PAD_VAL, in_data}, mark it padded, go to FULL.
- HALF + beat: word = {in_data, low}, go to FULL. `in_last` on this beat has no further effect.
- Launch: in any cycle where a word is complete (held in FULL, or completing this cycle) and `fifo_in_stall=0`:
  - next cycle `fifo_in_valid=1` and `fifo_in` = word;
  - `words_sent` increments; `pads_sent` also increments if the word was padded;
  - the state leaves FULL.
- Bypass: a beat that completes a word while `fifo_in_stall=0` launches directly, without spending a cycle in FULL.
- `in_ready` = !rst & (state != FULL | !fifo_in_stall).
  - When FULL and launching, a new beat is accepted the same cycle into the low half.
  - Next state is HALF, or FULL if that beat had `in_last=1` (a padded word).
- Back-to-back completion (a HALF beat completing while a FULL word launches) cannot occur: a new beat in FULL always lands in the low half.
- Stall safety:
  - Launches are decided from stall one cycle before the write strobe, so at most one write is in flight.
  - Stall asserts at ≤1 free slot, so that in-flight write always fits. The packer never causes FIFO overflow.
  - If `err_ovf` sets anyway, it indicates an external write or a FIFO fault.
- `fifo_in_stall` held high (override) freezes the packer in FULL with `in_ready=0`. No data is lost.
- Counters are modulo 2^CNT_W. Both counters may increment in the same cycle.
- Error flags set on any cycle their input is high, and clear only on `rst`.

## Timing
- Reset values (while `rst` high and the cycle after):
  - state EMPTY;
  - `fifo_in_valid=0`, `fifo_in=0`;
  - `in_ready=0` during reset;
  - `err_ovf=0`, `err_unf=0`;
  - `words_sent=0`, `pads_sent=0`.
- Reset mid-frame discards any held half or full word, with no write.
- Latency: completing beat accepted at cycle t with stall low → `fifo_in_valid` high at t+1.
- Throughput: one word every 2 cycles with continuous input and no stall.
- `fifo_in` is registered and holds its last value when `fifo_in_valid=0`.
- Sticky flags are registered: input pulse at t → flag high at t+1.

## Structure
- A shared package `cr_kme_packer_pkg` holds:
  - the state enum (EMPTY, HALF, FULL);
  - default constants `KME_IN_W=32` and `KME_PAD_VAL`.
- One sub-module, `cr_kme_sticky_cnt`, provides the wrapping counter with increment enable and synchronous clear. It is instantiated twice.
- The sticky error flags are inline registers.

## Test plan
- **Pair:** reset, then beats 32'hA, 32'hB (last) on consecutive cycles, stall low → one strobe, `fifo_in=64'h0000000B_0000000A`, at the cycle after B is accepted; `words_sent=1`, `pads_sent=0`.
- **Odd tail:** single beat 32'h1234 with `in_last=1`, PAD_VAL=32'hDEADBEEF → `fifo_in=64'hDEADBEEF_00001234`; `pads_sent=1`.
- **Stall hold:** complete a word while stall is high for 5 cycles → `in_ready=0`, no strobe for 5 cycles, then exactly one strobe with unchanged data 1 cycle after stall drops.
- **Streaming:** 16 beats continuous with stall toggling every 3 cycles, fed into the real FIFO model → 8 words in order, `err_ovf` stays 0, FIFO never exceeds depth.
- **Reset mid-frame:** accept 1 beat, assert `rst` → no strobe. Next pair 32'h5, 32'h6 → `64'h6_5` only.
- **Errors/wrap:** pulse `fifo_underflow` for one cycle → `err_unf=1` until reset. Preset `words_sent=16'hFFFF` by 65535 words, then one more word → 0.
